// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Requester side of the instruction-memory interface. Presents a line address
//   to a fixed-latency 64-bit-line instruction memory, captures the returned
//   line into a one-line buffer and streams 16-bit instructions to decode with
//   a valid/ready handshake. Handles sequential advance, refills and redirects.
//
// Parameters
//   MEM_LATENCY  posedges the memory needs to produce a line (must match memory)
//   RESET_PC     PC loaded on reset (bit 0 ignored)
//
// Ports
//   clk          system clock, all state changes on posedge
//   reset        asynchronous active-high reset
//   mem_address  registered line address {line[15:3],3'b000} to memory
//   mem_ins      64-bit line from memory, sampled only on the capture edge
//   if_ready     decode accepts if_instr this cycle
//   redirect     branch/jump taken, load redirect_pc
//   redirect_pc  new PC (bit 0 forced to 0)
//   if_valid     if_instr / if_pc are valid
//   if_instr     16-bit instruction at if_pc
//   if_pc        byte address of if_instr
//
// Optional feature (macro FETCH_PERF_CNT_EN)
//   perf_wait_cycles  32-bit saturating count of cycles spent waiting on memory
//   perf_redirects    16-bit saturating count of redirect pulses
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int          MEM_LATENCY = 5,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] mem_address,
    input  logic [63:0] mem_ins,
    input  logic        if_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_wait_cycles,
    output logic [15:0] perf_redirects
`endif
);

    localparam int               CNT_W         = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(MEM_LATENCY);
    localparam logic [15:0]      RESET_PC_EVEN = RESET_PC & 16'hFFFE;
    localparam logic [15:0]      RESET_LINE    = {RESET_PC[15:3], 3'b000};

    typedef enum logic [0:0] {
        ST_REQ   = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_n_s;
    logic [15:0]      pc_r;
    logic [15:0]      pc_n_s;
    logic [15:0]      addr_n_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_n_s;
    logic             line_valid_r;
    logic [12:0]      line_tag_r;
    logic [63:0]      line_buf_r;
    logic             capture_s;
    logic             transfer_s;
    logic [15:0]      pc_inc_s;
    logic [12:0]      tgt_line_s;

    // Select 16-bit instruction slot sel of a 64-bit line.
    function automatic logic [15:0] slot_word(input logic [63:0] line, input logic [1:0] sel);
        logic [15:0] w;
        case (sel)
            2'b00:   w = line[15:0];
            2'b01:   w = line[31:16];
            2'b10:   w = line[47:32];
            2'b11:   w = line[63:48];
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    // Next-state computation: memory wait/capture, sequential advance, redirect.
    always_comb begin
        state_n_s    = state_r;
        pc_n_s       = pc_r;
        addr_n_s     = mem_address;
        wait_cnt_n_s = wait_cnt_r;
        capture_s    = 1'b0;
        transfer_s   = (state_r == ST_SERVE) && if_ready;
        pc_inc_s     = pc_r + 16'd2;   // 16-bit add wraps FFFE -> 0000
        tgt_line_s   = redirect_pc[15:3];

        if (state_r == ST_REQ) begin
            if (wait_cnt_r == CNT_LAST) begin
                capture_s    = 1'b1;
                state_n_s    = ST_SERVE;
                wait_cnt_n_s = {CNT_W{1'b0}};
            end else begin
                wait_cnt_n_s = wait_cnt_r + CNT_W'(1);
            end
        end else begin
            if (transfer_s) begin
                pc_n_s = pc_inc_s;
                if (pc_r[2:1] == 2'b11) begin
                    state_n_s    = ST_REQ;
                    addr_n_s     = {pc_inc_s[15:3], 3'b000};
                    wait_cnt_n_s = {CNT_W{1'b0}};
                end else begin
                    state_n_s = ST_SERVE;
                end
            end else begin
                pc_n_s = pc_r;
            end
        end

        // Redirect overrides everything computed above except an ongoing
        // same-line wait, which must keep counting in step with the memory.
        if (redirect) begin
            pc_n_s = {redirect_pc[15:1], 1'b0};
            if (tgt_line_s == mem_address[15:3]) begin
                if (state_r == ST_SERVE) begin
                    state_n_s    = ST_SERVE;
                    addr_n_s     = mem_address;
                    wait_cnt_n_s = wait_cnt_r;
                end else begin
                    state_n_s = state_n_s;
                end
            end else if (line_valid_r && (tgt_line_s == line_tag_r)) begin
                // Buffered line hit: serve it. Point the address back at the
                // buffered line so that in SERVE mem_address always names it.
                state_n_s    = ST_SERVE;
                addr_n_s     = {line_tag_r, 3'b000};
                wait_cnt_n_s = {CNT_W{1'b0}};
                capture_s    = 1'b0;
            end else begin
                state_n_s    = ST_REQ;
                addr_n_s     = {tgt_line_s, 3'b000};
                wait_cnt_n_s = {CNT_W{1'b0}};
                capture_s    = 1'b0;
            end
        end else begin
            pc_n_s = pc_n_s;
        end
    end

    // State, PC, address and line-buffer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_REQ;
            pc_r         <= RESET_PC_EVEN;
            mem_address  <= RESET_LINE;
            wait_cnt_r   <= {CNT_W{1'b0}};
            line_valid_r <= 1'b0;
            line_tag_r   <= 13'h0000;
            line_buf_r   <= 64'h0000_0000_0000_0000;
        end else begin
            state_r     <= state_n_s;
            pc_r        <= pc_n_s;
            mem_address <= addr_n_s;
            wait_cnt_r  <= wait_cnt_n_s;
            if (capture_s) begin
                line_buf_r   <= mem_ins;
                line_tag_r   <= mem_address[15:3];
                line_valid_r <= 1'b1;
            end
        end
    end

    // Decode-side outputs, decoded from registered state only.
    always_comb begin
        if (state_r == ST_SERVE) begin
            if_valid = 1'b1;
            if_pc    = pc_r;
            if_instr = slot_word(line_buf_r, pc_r[2:1]);
        end else begin
            if_valid = 1'b0;
            if_pc    = 16'h0000;
            if_instr = 16'h0000;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_wait_cycles <= 32'h0000_0000;
            perf_redirects   <= 16'h0000;
        end else begin
            if ((state_r == ST_REQ) && (perf_wait_cycles != 32'hFFFF_FFFF)) begin
                perf_wait_cycles <= perf_wait_cycles + 32'd1;
            end
            if (redirect && (perf_redirects != 16'hFFFF)) begin
                perf_redirects <= perf_redirects + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Requester side of the instruction-memory interface.
- Drives a byte address into the 5-cycle-latency, 64-bit-line instruction memory and holds it stable for the access time.
- Captures the returned line into a one-line buffer, then streams 16-bit instructions to the decode stage with a valid/ready handshake.
- Handles sequential PC advance, line refills and branch redirects.

Parameters:
- MEM_LATENCY, 5: number of memory posedges needed to produce a line. Must match the memory.
- RESET_PC, 16'h0000: PC loaded on reset. Bit 0 is ignored.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- mem_address  out  16  line address to the instruction memory. Always {line[15:3],3'b000}. Registered.
- mem_ins  in  64  line from memory. Byte k of the line is bits [8k+7:8k]. Valid only on the capture edge; X otherwise.
- if_ready  in  1  decode stage accepts if_instr this cycle.
- redirect  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  16  new PC. Bit 0 is forced to 0.
- if_valid  out  1  if_instr/if_pc are valid.
- if_instr  out  16  instruction = {byte[2s+1], byte[2s]} of the buffered line, where s = pc[2:1].
- if_pc  out  16  byte address of if_instr.

Behaviour:
- Reset (async):
  - state = REQ, pc = RESET_PC & 16'hFFFE.
  - mem_address = {RESET_PC[15:3],3'b000}, wait_cnt = 0.
  - line_valid = 0, line_tag = 0, line_buf = 0.
  - if_valid = 0, if_instr = 0, if_pc = 0.
- Reset mid-fetch abandons the access. The refetch restarts with a full latency count.
- State REQ:
  - if_valid = 0. mem_address is held constant.
  - wait_cnt increments each posedge.
  - On the edge where wait_cnt == MEM_LATENCY (the (MEM_LATENCY+1)th posedge after mem_address changed): line_buf <= mem_ins, line_tag <= mem_address[15:3], line_valid <= 1, wait_cnt <= 0, go to SERVE.
  - Sequential or cold-start refill latency = MEM_LATENCY+1 cycles of if_valid = 0.
  - mem_ins is never sampled on any other edge.
- State SERVE:
  - if_valid = 1, if_pc = pc, if_instr = slice pc[2:1] of line_buf (combinational from registered state).
  - Handshake: a transfer occurs when if_valid && if_ready. With no transfer, outputs hold.
  - On a transfer: pc <= pc + 2, with wrap-around 16'hFFFE -> 16'h0000.
  - If pc[2:1] == 2'b11 at the transfer: go to REQ, mem_address <= {(pc+2)[15:3],3'b000}, wait_cnt <= 0. Otherwise stay in SERVE.
- Redirect (highest priority, any state):
  - pc <= {redirect_pc[15:1],1'b0}.
  - If in SERVE, or in REQ, and the target line equals the current mem_address line: keep state and wait_cnt, no new request. In REQ this avoids restarting a count the memory does not restart.
  - Else if line_valid && redirect_pc[15:3] == line_tag: go to SERVE with no memory access.
  - Else: go to REQ, mem_address <= target line, wait_cnt <= 0. An in-flight access is abandoned.
- Redirect and transfer in the same cycle: the instruction counts as consumed, and pc takes redirect_pc (the pc+2 path is ignored).
- if_ready asserted while if_valid = 0 is ignored.
- A redirect to an odd address is treated as the even address below it.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Extra output port perf_wait_cycles, 32 bits.
  - Increments every cycle the state is REQ; saturates at 32'hFFFFFFFF.
  - Cleared by reset.
  - Extra output port perf_redirects, 16 bits; counts redirect pulses; saturates.
- Undefined: neither port exists, no counter logic. All other behaviour is identical.

Test Plan:
- Memory model preloaded with line 0 bytes 0-1 = 88,E1; line 1 bytes 0-1 = 70,0C; line 2 bytes 0-1 = 8A,CF; all other bytes 0.
  - Reset with RESET_PC=0, if_ready=1 -> mem_address=0x0000. First if_valid after 6 posedges with if_instr=0xE188, if_pc=0x0000. Then 0x0000 at pc 2, 4, 6. Then mem_address=0x0008, 6-cycle bubble, then 0x0C70 at pc 8.
- if_ready=0 for 10 cycles while serving pc=0 -> if_valid=1, if_instr=0xE188, if_pc=0 held stable; mem_address unchanged.
- Redirect to 0x0010 while waiting in REQ for line 0x0008 -> mem_address=0x0010, wait restarts, if_instr=0xCF8A at if_pc=0x0010 after 6 cycles; line 1 data never presented.
- Redirect to 0x0004 while serving line 0 (transfer in the same cycle) -> next cycle if_pc=0x0004, if_instr=0x0000, no memory access, no bubble.
- RESET_PC=16'hFFFE, step through with if_ready=1 -> pc wraps to 0x0000, mem_address=0x0000, refill bubble of 6 cycles, then if_instr=0xE188.
- With FETCH_PERF_CNT_EN defined, run the first scenario through pc 8 -> perf_wait_cycles=12, perf_redirects=0. Assert reset mid-REQ -> both counters 0 and mem_address=RESET_PC line.
